ahb_bus_arbiter: RTL
====================

AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- DEFAULT_MASTER, 0, master granted when nobody requests.
- MAX_HOLD, 16, owner transfer beats before forced re-arbitration.
REQ-002 Ports SHALL be:
- HCLK  in  1  sole clock, all logic on rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  transfer type currently on shared address bus.
- HREADY  in  1  shared bus ready from the slave mux.
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  clog2(NUM_MASTERS)  index of address-phase owner, registered.
- HMASTLOCK  out  1  current owner's transfer is locked, registered.

Function
REQ-003 HGRANT SHALL always be exactly one-hot; HGRANT, HMASTER and HMASTLOCK SHALL be driven only from flops.
REQ-004 The FSM SHALL have states IDLE (default master parked), OWNED and LOCKED.
REQ-005 An arbitration point SHALL be any cycle with HREADY=1, state not LOCKED, and one of the following:
- the granted master has HBUSREQ=0;
- the hold count equals MAX_HOLD with HTRANS not SEQ;
- the state is IDLE.
REQ-006 At an arbitration point the winner SHALL be the first requesting master in round-robin order starting at (last owner + 1) mod NUM_MASTERS.
REQ-007 HGRANT SHALL take the winner one-hot at the clock edge ending that cycle; the last-owner pointer SHALL update to the winner.
REQ-008 With no HBUSREQ set at an arbitration point, HGRANT SHALL go to DEFAULT_MASTER and the state SHALL go to IDLE.
REQ-009 HMASTER SHALL load the index of HGRANT at the first edge with HREADY=1 after HGRANT changes. Grant-to-HMASTER latency is one cycle when HREADY=1; it is extended by each HREADY=0 cycle.
REQ-010 With a winner present, state transitions SHALL be:
- IDLE->OWNED on any winner;
- OWNED->LOCKED when the owner has HBUSREQ=1 and HLOCK=1 with HREADY=1;
- LOCKED->OWNED when the owner's HLOCK=0 with HREADY=1.
REQ-011 In LOCKED, HGRANT SHALL NOT change regardless of other requests or the hold count.
REQ-012 HMASTLOCK SHALL load HLOCK[granted] on the same edge HMASTER loads.
REQ-013 The hold counter SHALL:
- increment on each HREADY=1 cycle with HTRANS NONSEQ or SEQ;
- saturate at MAX_HOLD;
- clear to 0 on every HGRANT change.
REQ-014 Forced re-arbitration at MAX_HOLD SHALL occur only if another master requests; if the owner alone requests, the grant SHALL be kept and the counter SHALL stay saturated.
REQ-015 During HREADY=0, no output SHALL change (simultaneous request changes are sampled at the next HREADY=1 cycle).
REQ-016 A request edge and its deassertion in the same non-ready window SHALL produce no grant.

Reset
REQ-017 While HRESET=1 at an edge, the block SHALL reset to:
- HGRANT one-hot DEFAULT_MASTER;
- HMASTER=DEFAULT_MASTER;
- HMASTLOCK=0;
- state IDLE;
- hold count 0;
- last-owner pointer DEFAULT_MASTER.
REQ-018 Reset asserted mid-burst or in LOCKED SHALL override all other behaviour in that cycle. The first arbitration SHALL be possible in the first cycle after HRESET falls.

Structure
REQ-019 Package ahb_arb_pkg SHALL hold:
- htrans_t (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
- arb_state_t (IDLE, OWNED, LOCKED);
- default parameter constants.
REQ-020 Round-robin selection SHALL be a combinational sub-module ahb_rr_picker with inputs (requests, last-owner pointer) and outputs (winner index, valid).

Verification
REQ-021 Reset then no requests, HREADY=1 -> HGRANT=0001, HMASTER=0, state IDLE, stable for 10 cycles.
REQ-022 HBUSREQ=1010 at cycle 5, HREADY=1 -> HGRANT=0010 at cycle 6, HMASTER=1 at cycle 7. Master 1 drops its request -> HGRANT=1000 next edge.
REQ-023 All four request continuously with NONSEQ/SEQ bursts of 4 (MAX_HOLD=4) -> grants rotate 0,1,2,3,0. No switch ever follows a SEQ beat.
REQ-024 Master 2 holds HBUSREQ=1 and HLOCK=1 for 30 beats while masters 0, 1 and 3 request -> HGRANT stays 0100, HMASTLOCK=1. Regrant occurs one cycle after HLOCK falls.
REQ-025 Master 1 granted, HREADY held 0 for 3 cycles -> HMASTER updates only on the edge after HREADY returns to 1.
REQ-026 HRESET pulsed in LOCKED mid-burst -> next edge HGRANT=0001, HMASTLOCK=0, hold count 0.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared types and default parameters for the AHB bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWNED,
        ST_LOCKED
    } arb_state_t;

    localparam int DEF_NUM_MASTERS    = 4;
    localparam int DEF_DEFAULT_MASTER = 0;
    localparam int DEF_MAX_HOLD       = 16;

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester at or after (last + 1),
// wrapping so that the last owner itself is considered last.
module ahb_rr_picker
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int IW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IW-1:0]          i_last,
    output logic [IW-1:0]          o_winner,
    output logic                   o_valid
);

    always_comb begin
        logic [IW-1:0] v_idx;
        v_idx    = '0;
        o_winner = '0;
        o_valid  = 1'b0;
        // Scan farthest-first so the nearest requester overwrites the result.
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            v_idx = IW'((int'(i_last) + k) % NUM_MASTERS);
            if (i_req[v_idx]) begin
                o_winner = v_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant with default-master parking, hold-count
// forced re-arbitration and locked-transfer ownership.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter int DEFAULT_MASTER = DEF_DEFAULT_MASTER,
    parameter int MAX_HOLD       = DEF_MAX_HOLD,
    localparam int IW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [IW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0] DEF_IDX  = IW'(DEFAULT_MASTER);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_gidx;
    logic [IW-1:0]          r_last;
    logic [HW-1:0]          r_hold;
    logic [IW-1:0]          r_master;
    logic                   r_mastlock;

    arb_state_t             w_state_nxt;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IW-1:0]          w_gidx_nxt;
    logic [IW-1:0]          w_last_nxt;
    logic [HW-1:0]          w_hold_nxt;
    logic [IW-1:0]          w_win;
    logic                   w_win_vld;
    logic                   w_own_req;
    logic                   w_own_lock;
    logic                   w_beat;
    logic                   w_arb;
    logic                   w_clr;
    htrans_t                w_trans;

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_picker (
        .i_req    (HBUSREQ),
        .i_last   (r_last),
        .o_winner (w_win),
        .o_valid  (w_win_vld)
    );

    assign w_trans    = htrans_t'(HTRANS);
    assign w_own_req  = HBUSREQ[r_gidx];
    assign w_own_lock = HLOCK[r_gidx];
    assign w_beat     = HREADY && (w_trans == TR_NONSEQ || w_trans == TR_SEQ);
    // Never break a burst in the middle of a SEQ beat, never re-arbitrate while locked.
    assign w_arb      = HREADY && (r_state != ST_LOCKED) &&
                        (!w_own_req || (r_hold == HOLD_MAX && w_trans != TR_SEQ) ||
                         r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        w_clr       = 1'b0;
        if (w_arb) begin
            if (w_win_vld) begin
                w_gidx_nxt = w_win;
                w_last_nxt = w_win;
                if (r_state == ST_IDLE) begin
                    w_state_nxt = ST_OWNED;
                    w_clr       = 1'b1;
                end else if (w_win == r_gidx && w_own_lock) begin
                    w_state_nxt = ST_LOCKED;
                end
            end else begin
                w_gidx_nxt  = DEF_IDX;
                w_state_nxt = ST_IDLE;
                w_clr       = 1'b1;
            end
        end else if (HREADY) begin
            case (r_state)
                ST_OWNED:  if (w_own_req && w_own_lock) w_state_nxt = ST_LOCKED;
                ST_LOCKED: if (!w_own_lock) w_state_nxt = ST_OWNED;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_grant_nxt             = '0;
        w_grant_nxt[w_gidx_nxt] = 1'b1;
        w_hold_nxt              = r_hold;
        if (w_clr || (w_gidx_nxt != r_gidx)) begin
            w_hold_nxt = '0;
        end else if (w_beat && r_hold != HOLD_MAX) begin
            w_hold_nxt = r_hold + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state                 <= ST_IDLE;
            r_grant                 <= '0;
            r_grant[DEFAULT_MASTER] <= 1'b1;
            r_gidx                  <= DEF_IDX;
            r_last                  <= DEF_IDX;
            r_hold                  <= '0;
            r_master                <= DEF_IDX;
            r_mastlock              <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            // Address-phase owner follows the grant one ready beat later.
            if (HREADY) begin
                r_master   <= r_gidx;
                r_mastlock <= HLOCK[r_gidx];
            end
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

endmodule
